// File: rtl/snn_event_arbiter_pkg.sv
// Shared constants and types for the SNN event arbiter: address sizing,
// event source encoding and the output-register state.
package snn_pkg;

  localparam int ADDR_W   = 4;
  localparam int N_NEURON = 1 << ADDR_W;

  typedef enum logic {
    SRC_EXT = 1'b0,
    SRC_REC = 1'b1
  } evt_src_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/snn_event_arbiter_if.sv
// Handshake bundle for the arbiter: external event intake (valid/ready push)
// and the event channel offered to the core controller (valid/ready).
interface snn_event_arbiter_if
  import snn_pkg::*;
#(
  parameter int ADDR_W = snn_pkg::ADDR_W
);

  logic              ext_valid;
  logic [ADDR_W-1:0] ext_addr;
  logic              ext_ready;

  logic              evt_valid;
  logic [ADDR_W-1:0] evt_addr;
  evt_src_t          evt_src;
  logic              evt_ready;

  // Arbiter side
  modport master (
    input  ext_valid,
    input  ext_addr,
    output ext_ready,
    output evt_valid,
    output evt_addr,
    output evt_src,
    input  evt_ready
  );

  // Environment side: event producer plus core controller
  modport slave (
    output ext_valid,
    output ext_addr,
    input  ext_ready,
    input  evt_valid,
    input  evt_addr,
    input  evt_src,
    output evt_ready
  );

endinterface

// File: rtl/snn_event_arbiter_fifo.sv
// Small synchronous FIFO with show-ahead head data and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module snn_event_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/snn_event_arbiter.sv
// Event scheduler for the SNN core: merges external FIFO events and recurrent
// spike events into a single registered valid/ready stream.
module snn_event_arbiter
  import snn_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  parameter  int ADDR_W     = snn_pkg::ADDR_W,
  parameter  int N_NEURON   = snn_pkg::N_NEURON,
  parameter  int EXT_WEIGHT = 2,
  parameter  int CNT_W      = 8,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1,
  localparam int CR_W       = $clog2(EXT_WEIGHT + 1)
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  snn_event_arbiter_if.master  arb_if,
  input  logic [N_NEURON-1:0]  spike_i,
  input  logic                 spike_done_i,
  output logic [N_NEURON-1:0]  pending_o,
  output logic [LVL_W-1:0]     fifo_level_o,
  output logic [CNT_W-1:0]     merge_cnt_o
);

  // First set bit at or above ptr, wrapping; relies on N_NEURON == 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] rr_find(input logic [N_NEURON-1:0] mask,
                                                input logic [ADDR_W-1:0]   ptr);
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] res;
    logic              found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < N_NEURON; i++) begin
      idx = ptr + ADDR_W'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [ADDR_W-1:0]   fifo_head;

  out_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  evt_src_t            src_q, src_d;
  logic [N_NEURON-1:0] pending_q, pending_d;
  logic [ADDR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CR_W-1:0]     credit_q, credit_d;
  logic [CNT_W-1:0]    merge_cnt_q, merge_cnt_d;

  logic                handshake, load_en;
  logic                cand_e, cand_r, grant_ext, grant_rec, merge_hit;
  logic [ADDR_W-1:0]   rec_idx;
  logic [N_NEURON-1:0] clr;

  snn_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W)
  ) u_fifo (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .push_i  (fifo_push),
    .din_i   (arb_if.ext_addr),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  assign arb_if.ext_ready = enable_i & ~fifo_full & ~reset_i;
  assign fifo_push        = arb_if.ext_valid & arb_if.ext_ready;

  assign handshake = (state_q == OUT_HOLD) & arb_if.evt_ready & ~reset_i;
  assign load_en   = enable_i & ~reset_i & ((state_q == OUT_EMPTY) | handshake);

  assign cand_e    = ~fifo_empty;
  assign cand_r    = |pending_q;
  assign grant_ext = load_en & cand_e & (~cand_r | (credit_q < CR_W'(EXT_WEIGHT)));
  assign grant_rec = load_en & cand_r & ~grant_ext;
  assign fifo_pop  = grant_ext;
  assign rec_idx   = rr_find(pending_q, rr_ptr_q);

  // One-hot clear of the recurrent event being loaded this cycle.
  generate
    for (genvar gi = 0; gi < N_NEURON; gi++) begin : g_clr
      assign clr[gi] = grant_rec & (rec_idx == ADDR_W'(gi));
    end
  endgenerate

  // A bit freshly cleared by a grant and re-set by a spike is not a merge.
  assign merge_hit = spike_done_i & (|(pending_q & ~clr & spike_i));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    src_d       = src_q;
    rr_ptr_d    = rr_ptr_q;
    credit_d    = credit_q;
    merge_cnt_d = merge_cnt_q;
    pending_d   = pending_q & ~clr;
    if (spike_done_i) pending_d = pending_d | spike_i;
    if (merge_hit && (merge_cnt_q != '1)) merge_cnt_d = merge_cnt_q + CNT_W'(1);

    if (grant_ext) begin
      state_d  = OUT_HOLD;
      addr_d   = fifo_head;
      src_d    = SRC_EXT;
      credit_d = (credit_q < CR_W'(EXT_WEIGHT)) ? credit_q + CR_W'(1) : CR_W'(EXT_WEIGHT);
    end else if (grant_rec) begin
      state_d  = OUT_HOLD;
      addr_d   = rec_idx;
      src_d    = SRC_REC;
      rr_ptr_d = rec_idx + ADDR_W'(1);
      credit_d = '0;
    end else if (load_en || handshake) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= OUT_EMPTY;
      addr_q      <= '0;
      src_q       <= SRC_EXT;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      credit_q    <= '0;
      merge_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      src_q       <= src_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      merge_cnt_q <= merge_cnt_d;
    end
  end

  assign arb_if.evt_valid = (state_q == OUT_HOLD);
  assign arb_if.evt_addr  = addr_q;
  assign arb_if.evt_src   = src_q;
  assign pending_o        = pending_q;
  assign merge_cnt_o      = merge_cnt_q;

endmodule

// File: doc/snn_event_arbiter.md
Name: snn_event_arbiter

Overview:
- Schedules input events into the SNN core controller, which processes one event at a time.
- Two sources compete for the core:
  - external events arriving through a small FIFO;
  - recurrent events from neurons that fired, captured from the 16-bit spike vector on each spike_done pulse.
- Issues one event at a time to the controller over a valid/ready handshake.
- Arbitrates the two sources with a weighted credit scheme; the recurrent source uses round-robin across neurons.

Parameters:
- FIFO_DEPTH, 4, external event FIFO entries (power of 2, ≥2)
- ADDR_W, 4, event/neuron address width
- N_NEURON, 16, neurons in the core (= 2**ADDR_W)
- EXT_WEIGHT, 2, consecutive external grants allowed before a pending recurrent event must win
- CNT_W, 8, width of the merge counter

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  scheduler enable
- ext_valid  in  1  external event present
- ext_addr  in  ADDR_W  external event source address
- ext_ready  out  1  FIFO can accept
- spike  in  N_NEURON  neuron fire vector from core
- spike_done  in  1  spike vector valid this cycle
- evt_valid  out  1  event offered to controller
- evt_addr  out  ADDR_W  event address (drives controller event_addr)
- evt_src  out  1  0 = external, 1 = recurrent
- evt_ready  in  1  controller idle and accepting
- pending  out  N_NEURON  recurrent pending mask
- fifo_level  out  $clog2(FIFO_DEPTH)+1  external FIFO occupancy
- merge_cnt  out  CNT_W  saturating count of merged recurrent spikes

Behaviour:
- Reset (synchronous, active-high): clears FIFO, pending, credit, rr_ptr and merge_cnt.
  - evt_valid=0, evt_addr=0, evt_src=0, fifo_level=0.
  - ext_ready=0 while reset is high.
  - A held event is discarded; no handshake completes on a reset cycle.
- ext_ready = enable & !full & !reset.
  - Push on ext_valid&ext_ready.
  - No bypass path: an event pushed into an empty FIFO at edge N is eligible at N+1 and drives evt_valid after edge N+1 (2-cycle minimum latency).
- Recurrent capture on spike_done at the edge: pending <= (pending & ~clr) | spike.
  - clr is the one-hot grant of a recurrent event loaded this cycle.
  - Same bit cleared and set in the same cycle: set wins, no merge counted.
  - Bit already pending, not cleared, and spike bit high: merge. merge_cnt += 1 per cycle with ≥1 merge, saturating at all-ones.
  - Capture is active even when enable=0.
- Output register states:
  - EMPTY (evt_valid=0).
  - HOLD (evt_valid=1; evt_addr/evt_src stable until evt_ready).
  - Load is allowed when in EMPTY or when the HOLD handshake completes this cycle (back-to-back permitted), and enable=1.
- Arbitration, evaluated on a load cycle:
  - Candidates: E = FIFO non-empty; R = pending != 0.
  - E&R: grant external if credit < EXT_WEIGHT, else recurrent.
  - Only one candidate: grant it.
  - Neither: go to EMPTY.
  - An external grant pops the FIFO and credit <= min(credit+1, EXT_WEIGHT). A recurrent grant sets credit <= 0.
- Recurrent selection:
  - Pick the first set pending bit scanning upward from rr_ptr, wrapping N_NEURON-1 → 0.
  - evt_addr = index; rr_ptr <= index+1 (mod N_NEURON).
  - The pending bit is cleared at load, not at handshake.
- enable=0: no new loads and ext_ready=0. A HOLD event stays valid until accepted.
- Simultaneous FIFO push and pop on a non-full FIFO: level unchanged. Pop with push when full cannot occur, because ext_ready is low.

Decomposition:
- Package snn_pkg:
  - ADDR_W and N_NEURON constants.
  - typedef enum logic {SRC_EXT, SRC_REC} evt_src_t.
  - typedef enum logic {OUT_EMPTY, OUT_HOLD} out_state_t.
- Sub-module snn_event_fifo (parameterised sync FIFO with level output).
- The round-robin find-first logic stays inline as a function.

Test Plan:
- Reset mid-HOLD with evt_valid=1 → next cycle evt_valid=0, pending=0, fifo_level=0, merge_cnt=0; ext_ready=1 once reset is low and enable=1.
- Push ext_addr=5 into an empty FIFO, evt_ready=1 → evt_valid high exactly 2 cycles after push with evt_addr=5, evt_src=0, fifo_level back to 0.
- spike=16'h8001 with spike_done, rr_ptr=0, evt_ready=1 → events addr 0 then addr 15, src=1; pending=0 afterwards.
- FIFO holds 3 events, pending bit 7 set, EXT_WEIGHT=2, evt_ready=1 → grant order ext, ext, rec(7), ext.
- Pending bit 3 set and held with evt_ready=0, spike_done with spike=16'h0008 → merge_cnt=1 and pending unchanged. Separately, repeated merges saturate merge_cnt at 255.
- evt_valid=1 with evt_ready=0 for 10 cycles, then enable dropped → evt_addr/evt_src stable throughout; the event transfers when evt_ready rises; no further load while enable=0; ext_ready=0.
